// File: rtl/button_debounce.sv
// button_debounce: debounces the synchronized button level (metaFree) with a
// four-state FSM and produces a registered debounced level, a one-cycle
// press strobe and a wrapping press counter.
// Optional long-press strobe is built only when BUTTON_DEBOUNCE_LONG_PRESS_EN
// is defined; otherwise long_pulse is tied low.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 8,
  parameter int unsigned LONG_CYCLES     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             metaFree,
  output logic             pressed,
  output logic             pulse,
  output logic [CNT_W-1:0] press_count,
  output logic             long_pulse
);

  // Parameter legality checks at elaboration time.
  if (DEBOUNCE_CYCLES < 1) begin : g_chk_db
    $error("button_debounce: DEBOUNCE_CYCLES must be >= 1");
  end
  if (LONG_CYCLES < 1) begin : g_chk_long
    $error("button_debounce: LONG_CYCLES must be >= 1");
  end

  localparam int unsigned TW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [TW-1:0]   r_timer;
  logic [TW-1:0]   w_timer_next;
  logic            w_press_evt;
  logic            w_next_pressed;

  // Next-state and debounce-timer logic.
  always_comb begin
    w_next       = r_state;
    w_timer_next = r_timer;
    w_press_evt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (metaFree) begin
          w_next       = PRESS_WAIT;
          w_timer_next = '0;
        end
      end
      PRESS_WAIT: begin
        if (!metaFree) begin
          w_next = IDLE;
        end else if (r_timer == TIMER_LAST) begin
          w_next      = HELD;
          w_press_evt = 1'b1;
        end else begin
          w_timer_next = r_timer + TW'(1);
        end
      end
      HELD: begin
        if (!metaFree) begin
          w_next       = RELEASE_WAIT;
          w_timer_next = '0;
        end
      end
      RELEASE_WAIT: begin
        if (metaFree) begin
          w_next = HELD;
        end else if (r_timer == TIMER_LAST) begin
          w_next = IDLE;
        end else begin
          w_timer_next = r_timer + TW'(1);
        end
      end
      default: begin
        w_next       = IDLE;
        w_timer_next = '0;
      end
    endcase
  end

  assign w_next_pressed = (w_next == HELD) || (w_next == RELEASE_WAIT);

  // State register and registered outputs; pressed is derived from the next
  // state so it lines up with the state it describes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_timer     <= '0;
      pressed     <= 1'b0;
      pulse       <= 1'b0;
      press_count <= '0;
    end else begin
      r_state <= w_next;
      r_timer <= w_timer_next;
      pressed <= w_next_pressed;
      pulse   <= w_press_evt;
      if (w_press_evt) begin
        press_count <= press_count + CNT_W'(1);
      end
    end
  end

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
  localparam int unsigned HW = $clog2(LONG_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

  logic [HW-1:0] r_hold;
  logic          w_holding;

  assign w_holding = (r_state == HELD) || (r_state == RELEASE_WAIT);

  // Hold timer: cleared on debounced press, counts edges spent pressed and
  // saturates; the strobe fires on the edge it reaches LONG_CYCLES unless
  // that same edge completes the release.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold     <= '0;
      long_pulse <= 1'b0;
    end else begin
      long_pulse <= 1'b0;
      if (w_press_evt) begin
        r_hold <= '0;
      end else if (w_holding && (r_hold != HOLD_MAX)) begin
        r_hold <= r_hold + HW'(1);
        if ((r_hold == HOLD_LAST) && w_next_pressed) begin
          long_pulse <= 1'b1;
        end
      end
    end
  end
`else
  assign long_pulse = 1'b0;
`endif

endmodule
